// File: rtl/program_loader_if.sv
// program_loader_if: host-side load stream into the program loader.
// Ports (signals): load_valid, new_instruction, add_into, start_signal.
interface program_loader_if #(
    parameter int WORD_W = 32
);
    logic              load_valid;
    logic [WORD_W-1:0] new_instruction;
    logic              add_into;
    logic              start_signal;

    modport master (
        output load_valid,
        output new_instruction,
        output add_into,
        output start_signal
    );

    modport slave (
        input load_valid,
        input new_instruction,
        input add_into,
        input start_signal
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: captures a load stream into instruction memory, then
// data memory, tracks sizes, releases the core on start and reports end.
// Ports:
//   clk, reset (async active-low)   clock / reset
//   ld (program_loader_if.slave)     load stream: valid, word, target, start
//   core_halt                        core executed exit syscall (level)
//   imem_we/addr/wdata               registered instruction write port
//   dmem_we/addr/wdata               registered data write port
//   prog_size, data_size             saturating word counts
//   run, end_signal                  core enable / program finished
//   ovf_err                          sticky: a word was dropped (memory full)
//   load_csum                        only with PROGRAM_LOADER_CHECKSUM_EN:
//                                    modulo sum of every word written
module program_loader #(
    parameter int IADDR_W = 6,
    parameter int DADDR_W = 6,
    parameter int WORD_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    program_loader_if.slave    ld,
    input  logic               core_halt,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0]  imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [WORD_W-1:0]  dmem_wdata,
    output logic [IADDR_W:0]   prog_size,
    output logic [DADDR_W:0]   data_size,
    output logic               run,
    output logic               end_signal,
    output logic               ovf_err
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0]  load_csum
`endif
);

    typedef enum logic [1:0] {
        LOAD_I = 2'd0,
        LOAD_D = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Size values meaning "memory full" (exactly 2**ADDR_W words).
    localparam logic [IADDR_W:0] I_FULL = {1'b1, {IADDR_W{1'b0}}};
    localparam logic [DADDR_W:0] D_FULL = {1'b1, {DADDR_W{1'b0}}};

    state_t               state_q, state_d;
    logic                 imem_we_q, imem_we_d;
    logic [IADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0]    imem_wdata_q, imem_wdata_d;
    logic                 dmem_we_q, dmem_we_d;
    logic [DADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [WORD_W-1:0]    dmem_wdata_q, dmem_wdata_d;
    logic [IADDR_W:0]     prog_size_q, prog_size_d;
    logic [DADDR_W:0]     data_size_q, data_size_d;
    logic                 run_q, run_d;
    logic                 end_q, end_d;
    logic                 ovf_q, ovf_d;
    logic                 to_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LOAD_I;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            prog_size_q  <= '0;
            data_size_q  <= '0;
            run_q        <= 1'b0;
            end_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            prog_size_q  <= prog_size_d;
            data_size_q  <= data_size_d;
            run_q        <= run_d;
            end_q        <= end_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        prog_size_d  = prog_size_q;
        data_size_d  = data_size_q;
        run_d        = run_q;
        end_d        = end_q;
        ovf_d        = ovf_q;
        to_data      = 1'b0;

        case (state_q)
            LOAD_I, LOAD_D: begin
                if (ld.start_signal) begin
                    // Start wins over any word presented this cycle.
                    if (prog_size_q != '0) begin
                        state_d = RUN;
                        run_d   = 1'b1;
                    end else begin
                        state_d = DONE;
                        end_d   = 1'b1;
                    end
                end else begin
                    // Once data is selected it stays selected.
                    to_data = (state_q == LOAD_D) || ld.add_into;
                    if (to_data) begin
                        state_d = LOAD_D;
                    end
                    if (ld.load_valid && to_data) begin
                        if (data_size_q == D_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            dmem_we_d    = 1'b1;
                            dmem_addr_d  = data_size_q[DADDR_W-1:0];
                            dmem_wdata_d = ld.new_instruction;
                            data_size_d  = data_size_q + 1'b1;
                        end
                    end else if (ld.load_valid) begin
                        if (prog_size_q == I_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = prog_size_q[IADDR_W-1:0];
                            imem_wdata_d = ld.new_instruction;
                            prog_size_d  = prog_size_q + 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (core_halt) begin
                    state_d = DONE;
                    run_d   = 1'b0;
                    end_d   = 1'b1;
                end
            end
            DONE: begin
                run_d = 1'b0;
                end_d = 1'b1;
            end
            default: begin
                state_d = LOAD_I;
            end
        endcase
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign prog_size  = prog_size_q;
    assign data_size  = data_size_q;
    assign run        = run_q;
    assign end_signal = end_q;
    assign ovf_err    = ovf_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q, csum_d;

    // Only accepted words contribute; no writes happen from RUN onward,
    // so the sum freezes there naturally.
    always_comb begin
        csum_d = csum_q;
        if (imem_we_d || dmem_we_d) begin
            csum_d = csum_q + ld.new_instruction;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign load_csum = csum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized checks of program_loader
// against a transaction-level reference model.
module tb_program_loader;

    localparam int IW     = 6;
    localparam int DW     = 6;
    localparam int IDEPTH = 64;
    localparam int DDEPTH = 64;

    logic          clk;
    logic          reset;
    logic          core_halt;
    logic          imem_we;
    logic [IW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [IW:0]   prog_size;
    logic [DW:0]   data_size;
    logic          run;
    logic          end_signal;
    logic          ovf_err;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0]   load_csum;
`endif

    program_loader_if #(.WORD_W(32)) ld_if ();

    program_loader #(
        .IADDR_W(IW),
        .DADDR_W(DW),
        .WORD_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ld        (ld_if),
        .core_halt (core_halt),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .prog_size (prog_size),
        .data_size (data_size),
        .run       (run),
        .end_signal(end_signal),
        .ovf_err   (ovf_err)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        .load_csum (load_csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: phase flags, counts and memory images.
    bit          m_loading, m_to_data, m_running, m_done, m_ovf;
    int          m_psize, m_dsize;
    logic [31:0] m_csum;
    logic [31:0] ref_imem [IDEPTH];
    logic [31:0] ref_dmem [DDEPTH];
    logic [31:0] sh_imem  [IDEPTH];
    logic [31:0] sh_dmem  [DDEPTH];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_loading = 1'b1;
        m_to_data = 1'b0;
        m_running = 1'b0;
        m_done    = 1'b0;
        m_ovf     = 1'b0;
        m_psize   = 0;
        m_dsize   = 0;
        m_csum    = 32'h0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_iwe"}, 64'(imem_we), 64'd0);
        chk({tag, "_iaddr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_iwd"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_dwe"}, 64'(dmem_we), 64'd0);
        chk({tag, "_daddr"}, 64'(dmem_addr), 64'd0);
        chk({tag, "_dwd"}, 64'(dmem_wdata), 64'd0);
        chk({tag, "_psize"}, 64'(prog_size), 64'd0);
        chk({tag, "_dsize"}, 64'(data_size), 64'd0);
        chk({tag, "_run"}, 64'(run), 64'd0);
        chk({tag, "_end"}, 64'(end_signal), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf_err), 64'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk({tag, "_csum"}, 64'(load_csum), 64'd0);
`endif
    endtask

    // Assert reset asynchronously mid-cycle, hold it across one edge.
    task automatic do_reset();
        ld_if.load_valid      = 1'b0;
        ld_if.add_into        = 1'b0;
        ld_if.start_signal    = 1'b0;
        core_halt             = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_edge");
        reset = 1'b1;
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic cyc(input bit v, input logic [31:0] w, input bit a,
                       input bit s, input bit h);
        bit          e_iwe, e_dwe;
        int          e_ia, e_da;
        e_iwe = 1'b0;
        e_dwe = 1'b0;
        e_ia  = 0;
        e_da  = 0;
        ld_if.load_valid      = v;
        ld_if.new_instruction = w;
        ld_if.add_into        = a;
        ld_if.start_signal    = s;
        core_halt             = h;
        if (m_loading) begin
            if (s) begin
                m_loading = 1'b0;
                if (m_psize > 0) m_running = 1'b1;
                else m_done = 1'b1;
            end else begin
                if (a) m_to_data = 1'b1;
                if (v && m_to_data) begin
                    if (m_dsize == DDEPTH) m_ovf = 1'b1;
                    else begin
                        ref_dmem[m_dsize] = w;
                        e_dwe = 1'b1;
                        e_da  = m_dsize;
                        m_dsize++;
                        m_csum += w;
                    end
                end else if (v) begin
                    if (m_psize == IDEPTH) m_ovf = 1'b1;
                    else begin
                        ref_imem[m_psize] = w;
                        e_iwe = 1'b1;
                        e_ia  = m_psize;
                        m_psize++;
                        m_csum += w;
                    end
                end
            end
        end else if (m_running && h) begin
            m_running = 1'b0;
            m_done    = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("imem_we", 64'(imem_we), 64'(e_iwe));
        if (e_iwe) begin
            chk("imem_addr", 64'(imem_addr), 64'(e_ia));
            chk("imem_wdata", 64'(imem_wdata), 64'(w));
        end
        chk("dmem_we", 64'(dmem_we), 64'(e_dwe));
        if (e_dwe) begin
            chk("dmem_addr", 64'(dmem_addr), 64'(e_da));
            chk("dmem_wdata", 64'(dmem_wdata), 64'(w));
        end
        chk("prog_size", 64'(prog_size), 64'(m_psize));
        chk("data_size", 64'(data_size), 64'(m_dsize));
        chk("run", 64'(run), 64'(m_running));
        chk("end_signal", 64'(end_signal), 64'(m_done));
        chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk("load_csum", 64'(load_csum), 64'(m_csum));
`endif
        if (imem_we) sh_imem[imem_addr] = imem_wdata;
        if (dmem_we) sh_dmem[dmem_addr] = dmem_wdata;
    endtask

    task automatic mem_check(input string tag);
        for (int i = 0; i < m_psize; i++)
            chk({tag, "_imem"}, 64'(sh_imem[i]), 64'(ref_imem[i]));
        for (int j = 0; j < m_dsize; j++)
            chk({tag, "_dmem"}, 64'(sh_dmem[j]), 64'(ref_dmem[j]));
    endtask

    initial begin
        for (int i = 0; i < IDEPTH; i++) begin
            ref_imem[i] = 32'h0;
            sh_imem[i]  = 32'h0;
        end
        for (int i = 0; i < DDEPTH; i++) begin
            ref_dmem[i] = 32'h0;
            sh_dmem[i]  = 32'h0;
        end
        reset                 = 1'b0;
        core_halt             = 1'b0;
        ld_if.load_valid      = 1'b0;
        ld_if.new_instruction = 32'h0;
        ld_if.add_into        = 1'b0;
        ld_if.start_signal    = 1'b0;
        model_clear();
        #1;
        chk_zero("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic program + data load, then start.
        cyc(1, 32'h04150004, 0, 0, 0);
        cyc(1, 32'h04160005, 0, 0, 0);
        cyc(1, 32'h04170006, 0, 0, 0);
        cyc(1, 32'd10, 1, 0, 0);
        cyc(1, 32'hFFFFFFF6, 0, 0, 0);
        cyc(0, 32'h0, 0, 1, 0);
        chk("t1_run", 64'(run), 64'd1);
        chk("t1_psize", 64'(prog_size), 64'd3);
        chk("t1_dsize", 64'(data_size), 64'd2);
        chk("t1_i2", 64'(sh_imem[2]), 64'h04170006);
        chk("t1_d1", 64'(sh_dmem[1]), 64'hFFFFFFF6);
        mem_check("t1");

        // Word arriving with add_into's first assertion goes to dmem[0].
        do_reset();
        cyc(1, 32'h5072696E, 1, 0, 0);
        chk("prin_dwe", 64'(dmem_we), 64'd1);
        chk("prin_iwe", 64'(imem_we), 64'd0);
        chk("prin_daddr", 64'(dmem_addr), 64'd0);
        cyc(1, 32'h12345678, 0, 0, 0);
        chk("prin_next_daddr", 64'(dmem_addr), 64'd1);
        mem_check("prin");

        // Fill imem, then one word too many.
        do_reset();
        for (int i = 0; i < IDEPTH; i++) cyc(1, $urandom, 0, 0, 0);
        cyc(1, 32'hDEADBEEF, 0, 0, 0);
        chk("full_iwe", 64'(imem_we), 64'd0);
        chk("full_psize", 64'(prog_size), 64'd64);
        chk("full_ovf", 64'(ovf_err), 64'd1);
        cyc(0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, $urandom, 1, 0, 0);
        chk("full_ovf_run", 64'(ovf_err), 64'd1);
        mem_check("full");

        // Start with an empty program.
        do_reset();
        cyc(0, 32'h0, 0, 1, 0);
        chk("empty_end", 64'(end_signal), 64'd1);
        chk("empty_run", 64'(run), 64'd0);
        for (int i = 0; i < 4; i++) cyc(1, $urandom, i[0], 1, 1);

        // Halt after 5 run cycles, then stream noise.
        do_reset();
        cyc(1, 32'hA, 0, 0, 0);
        cyc(1, 32'hB, 0, 0, 0);
        cyc(0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, $urandom, i[0], 0, 0);
        cyc(0, 32'h0, 0, 0, 1);
        chk("halt_run", 64'(run), 64'd0);
        chk("halt_end", 64'(end_signal), 64'd1);
        for (int i = 0; i < 6; i++) cyc(1, $urandom, i[0], i[1], 0);

        // Reset in the middle of loading.
        do_reset();
        cyc(1, 32'h11111111, 0, 0, 0);
        cyc(1, 32'h22222222, 0, 0, 0);
        do_reset();
        chk("mid_psize", 64'(prog_size), 64'd0);
        cyc(1, 32'h33333333, 0, 0, 0);
        chk("mid_iaddr", 64'(imem_addr), 64'd0);
        chk("mid_iwe", 64'(imem_we), 64'd1);
        mem_check("mid");

        // Randomized sessions.
        for (int s = 0; s < 20; s++) begin
            int len_s;
            int a_div;
            int tot;
            do_reset();
            len_s = $urandom_range(0, 150);
            a_div = $urandom_range(2, 120);
            tot   = len_s + $urandom_range(5, 40);
            for (int i = 0; i < tot; i++) begin
                bit v, a, st, h;
                v  = ($urandom % 4) != 0;
                a  = ($urandom % a_div) == 0;
                st = (i == len_s) || (i > len_s && ($urandom % 5) == 0);
                h  = ($urandom % 8) == 0;
                cyc(v, $urandom, a, st, h);
            end
            mem_check("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Processor-side receiver for the program/data load stream that a bench or host drives into the core.
- The stream is carried on new_instruction, add_into and start_signal.
- The block captures words into instruction memory and then data memory, tracks program and data sizes, and releases the core on start.
- It reports completion back on end_signal once the core halts.
- Sits between the processor top-level load pins and the memory write ports.

Parameters:
IADDR_W, 6, instruction memory address width; depth = 2**IADDR_W words
DADDR_W, 6, data memory address width; depth = 2**DADDR_W words
WORD_W, 32, load word width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
load_valid  input  1  new_instruction holds a word to capture this cycle
new_instruction  input  WORD_W  load word (instruction or data)
add_into  input  1  target select: 0 = instruction memory, 1 = data memory
start_signal  input  1  end of load phase, begin execution
core_halt  input  1  core has executed exit syscall (level)
imem_we  output  1  instruction memory write strobe
imem_addr  output  IADDR_W  instruction write address
imem_wdata  output  WORD_W  instruction write data
dmem_we  output  1  data memory write strobe
dmem_addr  output  DADDR_W  data write address
dmem_wdata  output  WORD_W  data write data
prog_size  output  IADDR_W+1  number of instructions loaded
data_size  output  DADDR_W+1  number of data words loaded
run  output  1  core enable
end_signal  output  1  program finished
ovf_err  output  1  sticky: a write was dropped because a memory was full

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to LOAD_I.
  - All outputs are 0, including the address, data and size outputs.
- States: LOAD_I -> LOAD_D -> RUN -> DONE. No backward transitions except through reset.
- LOAD_I:
  - load_valid=1 and add_into=0: capture the word into imem at address prog_size, then prog_size+1.
  - add_into=1 sampled (with or without load_valid): go to LOAD_D. If load_valid=1 in that same cycle, the word is written to dmem address 0.
- LOAD_D:
  - load_valid=1: capture the word into dmem at address data_size, then data_size+1.
  - add_into returning to 0 is ignored; the target stays data.
- Write port timing:
  - Write ports are registered.
  - imem_we or dmem_we pulses high for exactly one cycle, in the cycle after the capturing edge.
  - addr/wdata are valid with the strobe; sizes update on the same edge as the strobe.
- Full:
  - prog_size == 2**IADDR_W: further instruction words are dropped, no strobe, and ovf_err is set.
  - data_size == 2**DADDR_W: same behaviour for data words.
  - Sizes saturate and never wrap.
- start_signal=1 sampled in LOAD_I or LOAD_D:
  - start has priority; any word in that cycle is dropped and no strobe is generated.
  - If prog_size > 0: go to RUN; run goes high on that edge.
  - If prog_size == 0: go directly to DONE; end_signal goes high and run stays 0.
- RUN:
  - load_valid, add_into and start_signal are ignored; no strobes.
  - core_halt=1 sampled: go to DONE; run=0 and end_signal=1 on that edge.
- DONE: end_signal held at 1, run held at 0, all inputs ignored until reset.
- Reset asserted mid-load or mid-run: immediate return to LOAD_I, sizes cleared, any pending strobe cancelled.
- ovf_err clears only on reset.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output load_csum, WORD_W wide.
  - Running modulo-2**WORD_W sum of every word actually written, covering both memories; dropped words are excluded.
  - Updates on the strobe edge, freezes from RUN onward, and resets to 0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Load 3 instructions 0x04150004, 0x04160005, 0x04170006, then add_into=1 and 2 data words 10 and 0xFFFFFFF6, then start -> imem[0..2] and dmem[0..1] hold those values; prog_size=3, data_size=2; run=1 the edge after start.
- Word presented with add_into rising in the same cycle (value 0x5072696E, "Prin") -> written to dmem[0], not to imem; state LOAD_D.
- Fill imem with 64 words, then a 65th word 0xDEADBEEF -> no imem_we; prog_size=64; ovf_err=1 and stays 1 through RUN.
- start with prog_size=0 -> end_signal=1 the next edge; run never asserts.
- RUN, then core_halt=1 after 5 cycles, then add_into toggles and load_valid pulses -> run falls and end_signal rises on the same edge; no strobes afterwards.
- Reset low mid-load after 2 instructions, then released -> prog_size=0, no strobe in the reset cycle; the next word is written at imem address 0. With the checksum macro defined, load_csum equals the sum of the words written after reset.
